// File: rtl/uart_pkg.sv
// Shared types and frame constants for the shared UART transmit path.
// Imported by the arbiter top and by anything that needs the frame layout.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } tx_state_e;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_STOP_BITS  = 1;
    localparam int DEF_FRAME_BITS = 1 + DEF_DATA_BITS + DEF_STOP_BITS;

    // Line bits per frame: start bit, data bits, stop bits.
    function automatic int frame_bits(input int data_bits, input int stop_bits);
        return 1 + data_bits + stop_bits;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_req_o
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                idx_o          = cand;
                grant_o[cand]  = 1'b1;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shares one 8N1-style tx line among NUM_REQ byte producers,
// with a one-entry holding register in front of a tick-paced serializer.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int STOP_BITS = DEF_STOP_BITS,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tx_enb,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [ID_W-1:0]              grant_id,
    output logic                         tx,
    output logic                         busy,
    output logic                         tx_done
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int SW = $clog2(STOP_BITS + 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic [SW-1:0]        stopcnt_q, stopcnt_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;

    logic                 consume;
    logic                 frame_end;
    logic                 fill;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [ID_W-1:0]      arb_idx;
    logic                 any_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .grant_o   (arb_grant),
        .idx_o     (arb_idx),
        .any_req_o (any_req)
    );

    // Every frame start (from IDLE or straight out of STOP) funnels through
    // the consume path so back-to-back frames share one load sequence.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        tx_d      = tx_q;
        consume   = 1'b0;
        frame_end = 1'b0;
        if (tx_enb) begin
            case (state_q)
                IDLE: begin
                    if (hold_valid_q) begin
                        consume = 1'b1;
                    end
                end
                DATA: begin
                    if (bitcnt_q == BW'(DATA_BITS)) begin
                        tx_d      = 1'b1;
                        stopcnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        tx_d     = shift_q[0];
                        shift_d  = shift_q >> 1;
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                STOP: begin
                    stopcnt_d = stopcnt_q + 1'b1;
                    if (stopcnt_q == SW'(STOP_BITS - 1)) begin
                        frame_end = 1'b1;
                        if (hold_valid_q) begin
                            consume = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
            if (consume) begin
                tx_d     = 1'b0;
                shift_d  = hold_data_q;
                bitcnt_d = '0;
                state_d  = DATA;
            end
        end
    end

    // A refill may land in the same cycle the serializer drains the hold.
    always_comb begin
        fill         = rst_n && any_req && (!hold_valid_q || consume);
        hold_valid_d = hold_valid_q && !consume;
        hold_data_d  = hold_data_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        if (fill) begin
            hold_valid_d = 1'b1;
            hold_data_d  = req_data[int'(arb_idx) * DATA_BITS +: DATA_BITS];
            grant_d      = arb_idx;
            ptr_d        = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            stopcnt_q    <= '0;
            tx_q         <= 1'b1;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            grant_q      <= '0;
            ptr_q        <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            stopcnt_q    <= stopcnt_d;
            tx_q         <= tx_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
        end
    end

    assign req_ready = fill ? arb_grant : '0;
    assign grant_id  = grant_q;
    assign tx        = tx_q;
    assign busy      = (state_q != IDLE) || hold_valid_q;
    assign tx_done   = frame_end;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART serial transmit line between NUM_REQ byte requesters.
- Selects requesters round-robin and serialises each byte as an 8N1-style frame (start, data LSB first, stop bits).
- Paces every bit on the one-cycle tx bit-rate tick from the baud generator.
- Sits between the baud generator and the pad-side tx line. Multiple producers (command responder, status reporter, debug logger) feed it.

Parameters:
- NUM_REQ, 4: number of requesters; ≥2.
- DATA_BITS, 8: data bits per frame.
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- ID_W, $clog2(NUM_REQ): width of grant_id.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tx_enb  input  1  bit-rate tick from the baud generator, one clk cycle high per bit period.
- req_valid  input  NUM_REQ  per-requester byte-valid.
- req_data  input  NUM_REQ*DATA_BITS  requester i byte at [i*DATA_BITS +: DATA_BITS].
- req_ready  output  NUM_REQ  one-hot accept pulse.
- grant_id  output  ID_W  index of last accepted requester.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line or a byte is held.
- tx_done  output  1  one-cycle pulse on the tick ending a frame's last stop bit.

Behaviour:
- Reset (async, rst_n=0):
  - tx=1, req_ready=0, busy=0, tx_done=0, grant_id=0.
  - hold_valid=0, state=IDLE, round-robin pointer=0.
  - Any frame in progress is abandoned immediately.
- Holding register (one entry: hold_data, hold_valid):
  - Fill condition: a cycle where hold_valid=0, or hold is being consumed this cycle, and any req_valid=1.
  - On fill, the arbiter picks the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[sel]=1 combinationally in that cycle only.
  - At the clock edge: hold_data<=req_data[sel], hold_valid<=1, grant_id<=sel, pointer<=(sel+1) mod NUM_REQ.
  - Requesters must keep req_valid and data stable until accepted. req_valid must not depend on req_ready.
- Serializer FSM: IDLE, DATA, STOP. Nothing changes on cycles with tx_enb=0.
- IDLE:
  - Condition: tx_enb=1 and hold_valid=1.
  - Actions: tx<=0 (start bit), shift<=hold_data, bitcnt<=0, hold consumed, next state DATA.
  - A hold filled on the same cycle as a tick is not visible to that tick; the frame starts at the next tick.
- DATA: on each tick:
  - If bitcnt=0: tx<=shift[0], shift>>=1, bitcnt<=bitcnt+1 (first data bit replaces the start bit).
  - Each tick drives the next LSB.
  - The tick after the last data bit has been driven: tx<=1, stopcnt<=0, next state STOP.
  - Net effect: each line bit lasts exactly one tick period.
- STOP:
  - Each tick increments stopcnt.
  - The tick ending stop bit STOP_BITS pulses tx_done and checks hold_valid:
    - hold_valid=1: starts the next frame immediately (tx<=0, load shift, go to DATA). No idle gap between frames.
    - hold_valid=0: go to IDLE with tx staying 1.
- Outputs:
  - busy = (state≠IDLE) | hold_valid.
  - tx is registered, with no combinational path from inputs.
- Simultaneous consume and fill in one cycle: the consumed value goes to shift, the new value goes to hold, and hold_valid stays 1.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 frames.
- Latency:
  - Accept: req_valid to req_ready is 0 cycles when hold is empty.
  - Start bit: tx falls at the first tick strictly after the fill edge.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE/DATA/STOP);
  - default DATA_BITS and STOP_BITS constants;
  - frame-length helper constant (1+DATA_BITS+STOP_BITS).
- Sub-module rr_arbiter (NUM_REQ), purely combinational:
  - inputs: req vector, pointer;
  - outputs: one-hot grant, encoded index, any_req.
- Pointer register stays in uart_tx_arbiter.

Test Plan:
- Common setup: tx_enb pulses every 10 clk from a baudrate instance with freq/baud=10, unless stated otherwise.
- Single frame: req_valid[2]=1 with byte 0xA5 ->
  - req_ready[2] pulses one cycle; grant_id=2;
  - tx = 0,1,0,1,0,0,1,0,1,1, each level 10 cycles;
  - tx_done pulses once; busy falls on the same edge.
- Four valid at once from reset with bytes 0x11,0x22,0x33,0x44 ->
  - accepts in order 0,1,2,3;
  - four back-to-back frames with no idle bit between stop and start;
  - tx_done count=4.
- Requesters 1 and 3 held valid continuously for 6 frames -> grant_id sequence 1,3,1,3,1,3; 0 and 2 never granted.
- req_valid asserted so the fill edge coincides with a tick ->
  - tx stays 1 at that tick;
  - start bit begins at the next tick, 10 cycles later.
- rst_n pulled low during data bit 4 of 0x5A with another request pending ->
  - tx=1, busy=0, req_ready=0 asynchronously;
  - after release, the pending requester is accepted and sends a complete fresh frame.
- STOP_BITS=2, byte 0xFF -> tx low for 10 cycles, then high for 100 cycles (8 data + 2 stop); tx_done at the final tick.
